calc_core: RTL and testbench

- Parametrised, handshaked execution core for the limited-function calculator.
- Replaces the fixed 32-bit add/sub datapath and the free-running, separately clocked multiplier with one single-clock unit.
- Accepts one decoded operation (funct, immA, immB) per start pulse and updates an internal accumulator.
- Single-cycle ops complete in 1 cycle. Multiply is an iterative shift-add taking IMM_W cycles.
- Sits between the instruction decoder and the PC/control logic. Control stalls the PC while busy is high.

---
 rtl/calc_core.sv | 172 +++++++++++++++++
 tb/tb_calc_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/calc_core.sv
// Handshaked calculator execution core: single-cycle ALU ops plus an iterative shift-add multiplier.
// Optional CALC_MAC_EN turns funct 110 into multiply-accumulate (acc + A*B); otherwise 110 is illegal.
module calc_core #(
  parameter int WIDTH   = 32,
  parameter int IMM_W   = 14,
  parameter int FUNCT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [IMM_W-1:0]   imm_a,
  input  logic [IMM_W-1:0]   imm_b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow,
  output logic               illegal
);
  localparam int PW = 2 * IMM_W;
  localparam int CW = $clog2(IMM_W + 1);

  localparam logic [FUNCT_W-1:0] F_ADD    = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] F_SUB    = FUNCT_W'(1);
  localparam logic [FUNCT_W-1:0] F_ACCADD = FUNCT_W'(2);
  localparam logic [FUNCT_W-1:0] F_ACCSUB = FUNCT_W'(3);
  localparam logic [FUNCT_W-1:0] F_MUL    = FUNCT_W'(4);
  localparam logic [FUNCT_W-1:0] F_CLR    = FUNCT_W'(5);
`ifdef CALC_MAC_EN
  localparam logic [FUNCT_W-1:0] F_MAC    = FUNCT_W'(6);
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [FUNCT_W-1:0] op_q;
  logic [IMM_W-1:0]   a_q, b_q;
  logic [PW-1:0]      mcand_q, prod_q;
  logic [IMM_W-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic               ovf_q, ill_q, done_q;

  logic launch_mul, accept, mul_step, wr_exec, wr_done;

  always_comb begin
    launch_mul = (funct == F_MUL);
`ifdef CALC_MAC_EN
    launch_mul = launch_mul || (funct == F_MAC);
`endif
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = launch_mul ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_IDLE;
      S_MUL:  if (cnt_q == CW'(IMM_W - 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs / datapath enables
  always_comb begin
    busy     = (state_q != S_IDLE);
    accept   = (state_q == S_IDLE) && start;
    mul_step = (state_q == S_MUL);
    wr_exec  = (state_q == S_EXEC);
    wr_done  = (state_q == S_DONE);
  end

  // single-cycle ALU; the extra MSB of each op is carry or borrow
  logic [WIDTH-1:0] a_x, b_x, ex_res;
  logic             ex_ovf, ex_ill;
  assign a_x = WIDTH'(a_q);
  assign b_x = WIDTH'(b_q);

  always_comb begin
    ex_res = acc_q;
    ex_ovf = 1'b0;
    ex_ill = 1'b0;
    case (op_q)
      F_ADD:    {ex_ovf, ex_res} = {1'b0, a_x} + {1'b0, b_x};
      F_SUB:    {ex_ovf, ex_res} = {1'b0, a_x} - {1'b0, b_x};
      F_ACCADD: {ex_ovf, ex_res} = {1'b0, a_x} + {1'b0, acc_q};
      F_ACCSUB: {ex_ovf, ex_res} = {1'b0, a_x} - {1'b0, acc_q};
      F_CLR:    ex_res = '0;
      default:  ex_ill = 1'b1;
    endcase
  end

  // widen the product so truncation detection works for any WIDTH vs 2*IMM_W
  logic [WIDTH+PW-1:0] prod_x;
  logic [WIDTH-1:0]    mul_res, dn_res;
  logic                mul_trunc, dn_ovf;
  assign prod_x    = (WIDTH+PW)'(prod_q);
  assign mul_res   = prod_x[WIDTH-1:0];
  assign mul_trunc = |prod_x[WIDTH+PW-1:WIDTH];

`ifdef CALC_MAC_EN
  logic [WIDTH:0] mac_sum;
  assign mac_sum = {1'b0, acc_q} + {1'b0, mul_res};
  always_comb begin
    dn_res = mul_res;
    dn_ovf = mul_trunc;
    if (op_q == F_MAC) begin
      dn_res = mac_sum[WIDTH-1:0];
      dn_ovf = mul_trunc | mac_sum[WIDTH];
    end
  end
`else
  assign dn_res = mul_res;
  assign dn_ovf = mul_trunc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= wr_exec | wr_done;
      if (accept) begin
        op_q     <= funct;
        a_q      <= imm_a;
        b_q      <= imm_b;
        mcand_q  <= PW'(imm_a);
        mplier_q <= imm_b;
        prod_q   <= '0;
        cnt_q    <= '0;
      end
      if (mul_step) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (wr_exec) begin
        acc_q <= ex_res;
        ovf_q <= ex_ovf;
        ill_q <= ex_ill;
      end
      if (wr_done) begin
        acc_q <= dn_res;
        ovf_q <= dn_ovf;
        ill_q <= 1'b0;
      end
    end
  end

  assign done     = done_q;
  assign result   = acc_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: driver pushes reference-model expectations, monitor checks each done.
module tb_calc_core;
  localparam int WIDTH = 32, IMM_W = 14, FUNCT_W = 3;
  localparam longint unsigned TWO32 = 64'h1_0000_0000;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [FUNCT_W-1:0] funct = '0;
  logic [IMM_W-1:0] imm_a = '0, imm_b = '0;
  logic busy, done, overflow, illegal;
  logic [WIDTH-1:0] result;

  calc_core #(.WIDTH(WIDTH), .IMM_W(IMM_W), .FUNCT_W(FUNCT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .imm_a(imm_a), .imm_b(imm_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .illegal(illegal));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0, n_fail = 0, cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] ref_acc = '0, vis = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the calculator's arithmetic rules on 64-bit integers.
  task automatic model(input logic [2:0] f, input logic [13:0] a, input logic [13:0] b, output exp_t e);
    longint unsigned A = a, B = b, C = ref_acc, p;
    e.res = ref_acc; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc_cyc = 0;
    case (f)
      3'd0: begin p = A + B; e.res = p[31:0]; e.ovf = (p >= TWO32); end
      3'd1: begin p = A - B; e.res = p[31:0]; e.ovf = (A < B); end
      3'd2: begin p = A + C; e.res = p[31:0]; e.ovf = (p >= TWO32); end
      3'd3: begin p = A - C; e.res = p[31:0]; e.ovf = (A < C); end
      3'd4: begin p = A * B; e.res = p[31:0]; e.ovf = (p >= TWO32); e.lat = IMM_W + 1; end
      3'd5: e.res = '0;
`ifdef CALC_MAC_EN
      3'd6: begin
        p = (A * B) % TWO32 + C;
        e.res = p[31:0]; e.ovf = (A * B >= TWO32) || (p >= TWO32); e.lat = IMM_W + 1;
      end
`endif
      default: e.ill = 1'b1;
    endcase
    ref_acc = e.res;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pops one expectation; between dones result must hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (done) begin
        if (sbq.size() == 0) chk("unexpected_done", done, 1'b0);
        else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("overflow", overflow, e.ovf);
          chk("illegal", illegal, e.ill);
          chk("latency", cyc - e.acc_cyc, e.lat);
          vis = e.res;
        end
      end else chk("result_hold", result, vis);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [13:0] a, input logic [13:0] b, input bit hammer);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (busy && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("idle_timeout", busy, 1'b0);
    start = 1'b1; funct = f; imm_a = a; imm_b = b;
    @(posedge clk); #1;
    model(f, a, b, e);
    e.acc_cyc = cyc;
    sbq.push_back(e);
    if (!hammer) start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    if (hammer) begin
      w = 0;
      while (busy && w < 100) begin
        funct = 3'($urandom); imm_a = 14'($urandom); imm_b = 14'($urandom);
        @(negedge clk); w++;
      end
      start = 1'b0;
    end
  endtask

  initial begin
    int w;
    bit any_done;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    reset = 1'b1;

    // abort a MUL with reset mid-operation
    @(negedge clk); start = 1'b1; funct = 3'd4; imm_a = 14'd3; imm_b = 14'd5;
    @(negedge clk); start = 1'b0;
    chk("mul_busy_pre_abort", busy, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 32'h0);
    @(negedge clk); reset = 1'b1;
    any_done = 1'b0;
    repeat (20) begin @(negedge clk); any_done |= done; end
    chk("abort_no_done", any_done, 1'b0);
    chk("abort_result_after", result, 32'h0);
    ref_acc = '0; vis = '0; mon_en = 1'b1;

    // directed
    issue(3'd0, 14'd10, 14'd20, 0);
    issue(3'd1, 14'd5, 14'd7, 0);
    issue(3'd5, 14'd0, 14'd0, 0);
    issue(3'd2, 14'd100, 14'd0, 0);
    issue(3'd3, 14'd250, 14'd0, 0);
    issue(3'd4, 14'h3FFF, 14'h3FFF, 0);
    issue(3'd4, 14'd123, 14'd45, 1);
    issue(3'd7, 14'd1, 14'd2, 0);
    issue(3'd5, 14'd0, 14'd0, 0);
    issue(3'd2, 14'd10, 14'd0, 0);
    issue(3'd6, 14'd3, 14'd4, 0);
    issue(3'd1, 14'd0, 14'd1, 0);
    issue(3'd2, 14'h3FFF, 14'd0, 0);
    issue(3'd0, 14'h3FFF, 14'h3FFF, 1);

    // randomized
    repeat (150) begin
      logic [13:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
      issue(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 3) == 0);
    end

    w = 0;
    while (sbq.size() != 0 && w < 200) begin @(negedge clk); w++; end
    chk("drain", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
